// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and constants for the cache port arbiter and its helpers.
//   arb_state_t  : arbiter FSM state encoding
//   cache_req_t  : one latched core-side request (addr, wdata, we, be)
//   PORT_IFETCH / PORT_DATA : conventional requester port indices
//   wrap_inc()   : cyclic increment of a port index
// ---------------------------------------------------------------------------
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } cache_req_t;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  // Next port index after idx, wrapping to 0 after n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin selector: picks the first asserted request at or
// after ptr, searching cyclically.
//   req    : request vector, one bit per port
//   ptr    : highest-priority port index for this search
//   valid  : at least one request is asserted
//   winner : index of the selected port (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from the far end back towards ptr so that the requester
  // with the smallest cyclic distance from ptr is the last one written.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx    = IDX_W'((int'(ptr) + off) % NUM_PORTS);
      winner = req[idx] ? idx : winner;
      valid  = valid | req[idx];
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
// Shares one cache core-side port (req/gnt/rvalid protocol) between
// NUM_PORTS requesters with round-robin selection and a single outstanding
// transaction.
//   clk, reset (async, active-high)
//   req_i/addr_i/wdata_i/we_i/be_i : per-port requests, port p at slice p
//   gnt_o/rvalid_o/error_o         : per-port handshake, owner port only
//   rdata_o                        : shared read data, qualify with rvalid_o
//   cache_req_o..cache_be_o        : latched request towards the cache
//   cache_gnt_i/rvalid_i/error_i/rdata_i : cache responses
// ---------------------------------------------------------------------------
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]    req_i,
  input  logic [NUM_PORTS*32-1:0] addr_i,
  input  logic [NUM_PORTS*32-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0]    we_i,
  input  logic [NUM_PORTS*4-1:0]  be_i,
  output logic [NUM_PORTS-1:0]    gnt_o,
  output logic [NUM_PORTS-1:0]    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic [NUM_PORTS-1:0]    error_o,
  output logic                    cache_req_o,
  output logic [31:0]             cache_addr_o,
  output logic [31:0]             cache_wdata_o,
  output logic                    cache_we_o,
  output logic [3:0]              cache_be_o,
  input  logic                    cache_gnt_i,
  input  logic                    cache_rvalid_i,
  input  logic                    cache_error_i,
  input  logic [31:0]             cache_rdata_i
);

  arb_state_t           state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     rr_ptr;
  cache_req_t           req_q;

  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_winner;
  logic [NUM_PORTS-1:0] owner_mask;
  logic                 accept;
  logic                 complete;

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req    (req_i),
    .ptr    (rr_ptr),
    .valid  (sel_valid),
    .winner (sel_winner)
  );

  assign owner_mask = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;

  // A grant only counts while the request is on the bus; a response only
  // counts once the transaction has been (or is being) granted. Everything
  // else from the cache is stray and ignored.
  assign accept   = (state == REQ) && cache_gnt_i;
  assign complete = cache_rvalid_i && ((state == WAIT_RSP) || accept);

  assign gnt_o    = accept ? owner_mask : {NUM_PORTS{1'b0}};
  assign rvalid_o = complete ? owner_mask : {NUM_PORTS{1'b0}};
  assign error_o  = (complete && cache_error_i) ? owner_mask : {NUM_PORTS{1'b0}};
  assign rdata_o  = cache_rdata_i;

  // The cache sees only the latched copy, so requester changes after
  // selection cannot disturb the issued transaction.
  assign cache_req_o   = (state == REQ);
  assign cache_addr_o  = req_q.addr;
  assign cache_wdata_o = req_q.wdata;
  assign cache_we_o    = req_q.we;
  assign cache_be_o    = req_q.be;

  // Arbitration FSM: select and latch in IDLE, present in REQ, await response
  // in WAIT_RSP; the round-robin pointer moves only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      req_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner       <= sel_winner;
            req_q.addr  <= addr_i[int'(sel_winner)*32 +: 32];
            req_q.wdata <= wdata_i[int'(sel_winner)*32 +: 32];
            req_q.we    <= we_i[sel_winner];
            req_q.be    <= be_i[int'(sel_winner)*4 +: 4];
            state       <= REQ;
          end
        end
        REQ: begin
          if (cache_gnt_i) begin
            if (cache_rvalid_i) begin
              rr_ptr <= IDX_W'(wrap_inc(int'(owner), NUM_PORTS));
              state  <= IDLE;
            end else begin
              state  <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (cache_rvalid_i) begin
            rr_ptr <= IDX_W'(wrap_inc(int'(owner), NUM_PORTS));
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
// Directed stimulus for cache_port_arbiter with a transaction-level model:
// the model tracks which port owns the cache and whether it has been granted,
// and a compare process checks every output on each falling edge. Hand
// computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_i;
  logic [N*32-1:0] addr_i;
  logic [N*32-1:0] wdata_i;
  logic [N-1:0]    we_i;
  logic [N*4-1:0]  be_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rvalid_o;
  logic [31:0]     rdata_o;
  logic [N-1:0]    error_o;
  logic            cache_req_o;
  logic [31:0]     cache_addr_o;
  logic [31:0]     cache_wdata_o;
  logic            cache_we_o;
  logic [3:0]      cache_be_o;
  logic            cache_gnt_i;
  logic            cache_rvalid_i;
  logic            cache_error_i;
  logic [31:0]     cache_rdata_i;

  int checks = 0;
  int errors = 0;

  cache_port_arbiter #(.NUM_PORTS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .error_o        (error_o),
    .cache_req_o    (cache_req_o),
    .cache_addr_o   (cache_addr_o),
    .cache_wdata_o  (cache_wdata_o),
    .cache_we_o     (cache_we_o),
    .cache_be_o     (cache_be_o),
    .cache_gnt_i    (cache_gnt_i),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_error_i  (cache_error_i),
    .cache_rdata_i  (cache_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy;     // a transaction is owned by some port
  bit          m_granted;  // the cache has accepted it, response pending
  int          m_owner;
  int          m_ptr;
  int          m_pick;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  int          grant_log[$];

  function automatic int first_req(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always_comb m_pick = first_req(req_i, m_ptr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy    <= 1'b0;
      m_granted <= 1'b0;
      m_owner   <= 0;
      m_ptr     <= 0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_we      <= 1'b0;
      m_be      <= '0;
      grant_log.delete();
    end else if (!m_busy) begin
      if (m_pick >= 0) begin
        m_busy    <= 1'b1;
        m_granted <= 1'b0;
        m_owner   <= m_pick;
        m_addr    <= addr_i[m_pick*32 +: 32];
        m_wdata   <= wdata_i[m_pick*32 +: 32];
        m_we      <= we_i[m_pick];
        m_be      <= be_i[m_pick*4 +: 4];
      end
    end else if (!m_granted) begin
      if (cache_gnt_i) begin
        grant_log.push_back(m_owner);
        if (cache_rvalid_i) begin
          m_busy <= 1'b0;
          m_ptr  <= (m_owner + 1) % N;
        end else begin
          m_granted <= 1'b1;
        end
      end
    end else if (cache_rvalid_i) begin
      m_busy    <= 1'b0;
      m_granted <= 1'b0;
      m_ptr     <= (m_owner + 1) % N;
    end
  end

  logic [N-1:0] e_own;
  bit           e_req, e_acc, e_done;

  always_comb begin
    e_own          = '0;
    e_own[m_owner] = 1'b1;
    e_req          = m_busy && !m_granted;
    e_acc          = e_req && cache_gnt_i;
    e_done         = m_busy && (m_granted || e_acc) && cache_rvalid_i;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_gnt",       gnt_o,       e_acc ? e_own : '0);
      chk("cyc_rvalid",    rvalid_o,    e_done ? e_own : '0);
      chk("cyc_error",     error_o,     (e_done && cache_error_i) ? e_own : '0);
      chk("cyc_rdata",     rdata_o,     cache_rdata_i);
      chk("cyc_cache_req", cache_req_o, e_req);
      if (e_req) begin
        chk("cyc_addr",  cache_addr_o,  m_addr);
        chk("cyc_wdata", cache_wdata_o, m_wdata);
        chk("cyc_we",    cache_we_o,    m_we);
        chk("cyc_be",    cache_be_o,    m_be);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cache();
    cache_gnt_i    = 1'b0;
    cache_rvalid_i = 1'b0;
    cache_error_i  = 1'b0;
    cache_rdata_i  = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] b);
    addr_i[p*32 +: 32]  = a;
    wdata_i[p*32 +: 32] = d;
    we_i[p]             = w;
    be_i[p*4 +: 4]      = b;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},    gnt_o,         32'h0);
    chk({nm, "_rvalid"}, rvalid_o,      32'h0);
    chk({nm, "_error"},  error_o,       32'h0);
    chk({nm, "_req"},    cache_req_o,   32'h0);
    chk({nm, "_addr"},   cache_addr_o,  32'h0);
    chk({nm, "_wdata"},  cache_wdata_o, 32'h0);
    chk({nm, "_we"},     cache_we_o,    32'h0);
    chk({nm, "_be"},     cache_be_o,    32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    req_i   = '0;
    addr_i  = '0;
    wdata_i = '0;
    we_i    = '0;
    be_i    = '0;
    clear_cache();
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    reset = 1'b0;

    // Single port 0 read: gnt two cycles after req, rvalid three after gnt.
    tick();
    set_port(0, 32'h0000_0040, 32'h0, 1'b0, 4'hF);
    req_i = 2'b01;
    tick();
    #1 chk("t1_cache_req", cache_req_o, 32'h1);
    chk("t1_addr", cache_addr_o, 32'h0000_0040);
    tick();
    cache_gnt_i = 1'b1;
    #1 chk("t1_gnt", gnt_o, 32'h1);
    tick();
    cache_gnt_i = 1'b0;
    req_i       = 2'b00;
    tick();
    tick();
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hDEAD_BEEF;
    #1 chk("t1_rvalid", rvalid_o, 32'h1);
    chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
    tick();
    clear_cache();

    // Both ports requesting continuously from a fresh reset: 0,1,0,1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(0, 32'h0000_1000, 32'h0000_00A0, 1'b0, 4'hF);
    set_port(1, 32'h0000_2000, 32'h0000_00B0, 1'b1, 4'h3);
    req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      cache_gnt_i = 1'b1;
      #1 chk("t2_gnt_order", gnt_o, (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      cache_gnt_i    = 1'b0;
      cache_rvalid_i = 1'b1;
      cache_rdata_i  = 32'(i);
      if (i == 3) req_i = 2'b00;
      #1 chk("t2_no_req_in_wait", cache_req_o, 32'h0);
      tick();
      clear_cache();
    end
    chk("t2_log_size", grant_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("t2_log", grant_log[i], 32'(i % 2));
    end

    // Port 1 write; address changes after selection must not leak through.
    set_port(0, 32'hFFFF_0000, 32'h0, 1'b0, 4'hF);
    set_port(1, 32'h0000_0100, 32'h1234_5678, 1'b1, 4'b0011);
    req_i = 2'b10;
    tick();
    addr_i[32 +: 32] = 32'h0000_0200;
    #1 chk("t3_addr_a", cache_addr_o, 32'h0000_0100);
    chk("t3_wdata", cache_wdata_o, 32'h1234_5678);
    chk("t3_be", cache_be_o, 32'h3);
    chk("t3_we", cache_we_o, 32'h1);
    tick();
    #1 chk("t3_addr_b", cache_addr_o, 32'h0000_0100);
    tick();
    cache_gnt_i = 1'b1;
    #1 chk("t3_gnt", gnt_o, 32'h2);
    chk("t3_addr_gnt", cache_addr_o, 32'h0000_0100);
    tick();
    cache_gnt_i = 1'b0;
    req_i       = 2'b00;
    tick();
    cache_rvalid_i = 1'b1;
    cache_error_i  = 1'b1;
    cache_rdata_i  = 32'h0000_0055;
    #1 chk("t3_rvalid", rvalid_o, 32'h2);
    chk("t3_error", error_o, 32'h2);
    tick();
    clear_cache();

    // Grant and response in the same REQ cycle.
    set_port(0, 32'h0000_0080, 32'h0, 1'b0, 4'hF);
    req_i = 2'b01;
    tick();
    cache_gnt_i    = 1'b1;
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hCAFE_F00D;
    #1 chk("t4_gnt", gnt_o, 32'h1);
    chk("t4_rvalid", rvalid_o, 32'h1);
    chk("t4_rdata", rdata_o, 32'hCAFE_F00D);
    tick();
    clear_cache();
    req_i = 2'b00;
    #1 chk("t4_idle_req", cache_req_o, 32'h0);

    // Reset while port 1 waits for its response.
    set_port(1, 32'h0000_0300, 32'h0, 1'b0, 4'hF);
    req_i = 2'b10;
    tick();
    tick();
    cache_gnt_i = 1'b1;
    tick();
    cache_gnt_i = 1'b0;
    req_i       = 2'b00;
    #1 chk("t5_model_ptr_before", m_ptr, 32'd1);
    reset = 1'b1;
    #1 chk_all_zero("t5_reset");
    tick();
    reset          = 1'b0;
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'h0000_0077;
    #1 chk("t5_stale_rvalid", rvalid_o, 32'h0);
    tick();
    clear_cache();
    req_i = 2'b11;
    #1 chk("t5_model_ptr_after", m_ptr, 32'd0);
    tick();
    cache_gnt_i = 1'b1;
    #1 chk("t5_gnt_port0", gnt_o, 32'h1);
    tick();
    cache_gnt_i    = 1'b0;
    cache_rvalid_i = 1'b1;
    req_i          = 2'b00;
    tick();
    clear_cache();

    // Stray gnt/rvalid/error while idle with nobody requesting.
    cache_gnt_i    = 1'b1;
    cache_rvalid_i = 1'b1;
    cache_error_i  = 1'b1;
    #1 chk("t6_rvalid", rvalid_o, 32'h0);
    chk("t6_error", error_o, 32'h0);
    chk("t6_gnt", gnt_o, 32'h0);
    tick();
    clear_cache();
    req_i = 2'b11;
    #1 chk("t6_model_ptr", m_ptr, 32'd1);
    tick();
    cache_gnt_i = 1'b1;
    #1 chk("t6_gnt_port1", gnt_o, 32'h2);
    tick();
    cache_gnt_i    = 1'b0;
    cache_rvalid_i = 1'b1;
    req_i          = 2'b00;
    tick();
    clear_cache();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares one set_associative_cache core-side port between NUM_PORTS requesters (default: instruction fetch = port 0, LSU data = port 1) using the PULPino req/gnt/rvalid protocol. Selects one requester round-robin and registers its request. Keeps exactly one transaction outstanding, because the cache accepts one at a time. Routes gnt, rvalid, rdata and error back to the owning port only.

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
IDX_W, $clog2(NUM_PORTS) (min 1), width of owner/pointer index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_i  in  NUM_PORTS  per-port request
addr_i  in  NUM_PORTS*32  per-port address, port p at [p*32+:32]
wdata_i  in  NUM_PORTS*32  per-port write data
we_i  in  NUM_PORTS  per-port write enable
be_i  in  NUM_PORTS*4  per-port byte enables
gnt_o  out  NUM_PORTS  per-port grant
rvalid_o  out  NUM_PORTS  per-port response valid
rdata_o  out  32  response data, shared bus, qualified by rvalid_o
error_o  out  NUM_PORTS  per-port error, qualified by rvalid_o
cache_req_o / cache_addr_o / cache_wdata_o / cache_we_o / cache_be_o  out  1/32/32/1/4  to cache core side
cache_gnt_i / cache_rvalid_i / cache_error_i  in  1/1/1  from cache
cache_rdata_i  in  32  from cache

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, owner 0, latched request fields 0. Async reset may hit any state: the in-flight transaction is abandoned and no rvalid is delivered.
- State IDLE:
  - If any req_i is high, choose winner = first requesting port at or after rr_ptr (cyclic search).
  - Register owner and the winner's addr, wdata, we and be.
  - Go to REQ. Arbitration costs 1 cycle.
- State REQ:
  - cache_req_o=1; cache_* fields driven from the registered copy, stable until grant.
  - On cache_gnt_i: gnt_o[owner]=1 combinationally, same cycle.
  - If cache_rvalid_i is also high that cycle, complete as in WAIT_RSP and go to IDLE; otherwise go to WAIT_RSP.
- State WAIT_RSP:
  - cache_req_o=0.
  - On cache_rvalid_i: rvalid_o[owner]=1, error_o[owner]=cache_error_i, rdata_o=cache_rdata_i (all combinational).
  - rr_ptr <= owner+1, wrapping to 0 after NUM_PORTS-1.
  - Go to IDLE.
- gnt_o and rvalid_o are one-hot or zero. Non-owner ports never see gnt or rvalid.
- rdata_o passes cache_rdata_i through unconditionally. Consumers must qualify it with rvalid_o.
- Requester rule: a port holds req_i and its fields until it sees gnt_o. Only the registered copy is used, so a late change or a drop of req_i after selection does not affect the issued transaction.
- Stray inputs: cache_gnt_i outside REQ and cache_rvalid_i in IDLE are ignored; no state change and no outputs.
- Fairness: a port that keeps requesting is served within NUM_PORTS transactions. A single requester is served back-to-back; each transaction takes one IDLE cycle plus the cache latency.
- rr_ptr changes only on completion, never on selection.

Decomposition:
- Shared package cache_arb_pkg:
  - state typedef (IDLE=2'b00, REQ=2'b01, WAIT_RSP=2'b10);
  - request struct {addr[31:0], wdata[31:0], we, be[3:0]};
  - localparam PORT_IFETCH=0, PORT_DATA=1.
- One sub-module rr_select:
  - combinational inputs: req vector, pointer;
  - outputs: valid and winner index;
  - reusable for the planned memory-side arbiter.

Test Plan:
- Single port 0 read, addr 0x0000_0040; cache gnt 2 cycles after req, rvalid 3 cycles later with rdata 0xDEADBEEF -> gnt_o=2'b01 on the cache gnt cycle, rvalid_o=2'b01 with rdata_o=0xDEADBEEF, gnt_o[1]/rvalid_o[1] stay 0 throughout.
- Both ports request continuously from reset (rr_ptr=0) -> grant order 0,1,0,1 over four transactions; cache_req_o never high in WAIT_RSP.
- Port 1 write, addr 0x100, wdata 0x12345678, be 4'b0011; port 1 changes addr to 0x200 one cycle after selection -> cache_addr_o=0x100, cache_wdata_o=0x12345678, cache_be_o=4'b0011 until cache gnt.
- cache_gnt_i and cache_rvalid_i high in the same REQ cycle -> gnt_o and rvalid_o pulse together for owner, state returns to IDLE next cycle.
- Reset asserted in WAIT_RSP with port 1 as owner -> all outputs 0 immediately; a cache_rvalid_i after reset release produces no rvalid_o; next arbitration starts from rr_ptr=0.
- cache_rvalid_i pulsed while IDLE with no requests, cache_error_i=1 -> rvalid_o=0 and error_o=0 on all ports, rr_ptr unchanged.
